// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two requester ports plus the single-port RAM command/response.
// The slave modport is the arbiter's view, the master modport the requesters'/RAM's view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p1_req;
  logic              p0_we;
  logic              p1_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_gnt;
  logic              p1_gnt;
  logic              p0_done;
  logic              p1_done;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              ram_en;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, ram_rdata,
    output p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
           ram_en, ram_rw, ram_addr, ram_wdata, busy
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, ram_rdata,
    input  p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
           ram_en, ram_rw, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for a single-port synchronous RAM (port 0 = CPU, port 1 = loader/debug).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to port 1.
module ram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            r_state;
  logic              r_win;
  logic [2:0]        r_cnt;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic              r_en;
  logic              r_rw;
  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_pick;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic              r_last;

  always_comb begin
    w_pick = bus.p1_req;
    if (bus.p0_req && bus.p1_req) w_pick = ~r_last;
  end
`else
  always_comb begin
    w_pick = bus.p1_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_win    <= 1'b0;
      r_cnt    <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_en     <= 1'b0;
      r_rw     <= 1'b0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      r_last   <= 1'b1;
`endif
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_en    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.p0_req || bus.p1_req) begin
            r_win   <= w_pick;
            r_rw    <= w_pick ? bus.p1_we    : bus.p0_we;
            r_addr  <= w_pick ? bus.p1_addr  : bus.p0_addr;
            r_wdata <= w_pick ? bus.p1_wdata : bus.p0_wdata;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt <= 3'(RAM_LAT - 1);
`ifdef RAM_ARB_ROUND_ROBIN_EN
          r_last <= r_win;
`endif
          if (RAM_LAT > 1) begin
            r_state <= WAIT;
          end else begin
            r_done0 <= ~r_win;
            r_done1 <= r_win;
            r_state <= DONE;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_done0 <= ~r_win;
            r_done1 <= r_win;
            r_state <= DONE;
          end
        end
        DONE: begin
          // Capture at the end of DONE so rdata holds the read value after the pulse.
          if (!r_rw) begin
            if (r_win) r_rdata1 <= bus.ram_rdata;
            else       r_rdata0 <= bus.ram_rdata;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // During DONE the RAM output is forwarded so rdata is already valid alongside done.
  assign bus.p0_rdata  = (r_done0 && !r_rw) ? bus.ram_rdata : r_rdata0;
  assign bus.p1_rdata  = (r_done1 && !r_rw) ? bus.ram_rdata : r_rdata1;
  assign bus.p0_gnt    = r_gnt0;
  assign bus.p1_gnt    = r_gnt1;
  assign bus.p0_done   = r_done0;
  assign bus.p1_done   = r_done1;
  assign bus.ram_en    = r_en;
  assign bus.ram_rw    = r_rw;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM_LAT=1 and RAM_LAT=3 instances, a transaction-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();
  ram_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus3 ();

  ram_arbiter #(.ADDR_W(8), .DATA_W(16), .RAM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  ram_arbiter #(.ADDR_W(8), .DATA_W(16), .RAM_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // RAM models: synchronous, read data appears RAM_LAT cycles after the strobe edge
  logic [15:0] ram1 [256];
  logic [15:0] ram3 [256];
  logic [15:0] pipe1;
  logic [15:0] pipe3 [3];

  always @(posedge clk) begin
    if (bus1.ram_en && bus1.ram_rw) ram1[bus1.ram_addr] <= bus1.ram_wdata;
    pipe1 <= (bus1.ram_en && !bus1.ram_rw) ? ram1[bus1.ram_addr] : 16'hDEAD;
  end
  assign bus1.ram_rdata = pipe1;

  always @(posedge clk) begin
    if (bus3.ram_en && bus3.ram_rw) ram3[bus3.ram_addr] <= bus3.ram_wdata;
    pipe3[0] <= (bus3.ram_en && !bus3.ram_rw) ? ram3[bus3.ram_addr] : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.ram_rdata = pipe3[2];

  function automatic logic [15:0] init_val(input int a);
    if (a == 8'h12) return 16'hBEEF;
    if (a == 8'h34) return 16'hC0DE;
    return {8'hA5, 8'(a)};
  endfunction

  // Reference model: phase = cycles of the access still to run (lat+1 = grant cycle, 1 = done cycle)
  int          m_ph   [2];
  logic        m_win  [2];
  logic        m_last [2];
  logic        m_rw   [2];
  logic [7:0]  m_addr [2];
  logic [15:0] m_wd   [2];
  logic [15:0] m_rd   [2];
  logic [15:0] m_rdata [2][2];
  logic [15:0] sh [2][256];

  task automatic model_step(input int i, input int lat, input logic rst,
                            input logic r0, input logic r1, input logic we0, input logic we1,
                            input logic [7:0] a0, input logic [7:0] a1,
                            input logic [15:0] d0, input logic [15:0] d1);
    logic w;
    if (rst) begin
      m_ph[i] = 0; m_last[i] = 1'b1; m_win[i] = 1'b0; m_rw[i] = 1'b0;
      m_addr[i] = '0; m_wd[i] = '0; m_rdata[i][0] = '0; m_rdata[i][1] = '0;
    end else if (m_ph[i] == 0) begin
      if (r0 || r1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        w = (r0 && r1) ? !m_last[i] : r1;
`else
        w = r1;
`endif
        m_win[i] = w; m_last[i] = w;
        m_rw[i] = w ? we1 : we0; m_addr[i] = w ? a1 : a0; m_wd[i] = w ? d1 : d0;
        if (m_rw[i]) sh[i][m_addr[i]] = m_wd[i];
        else         m_rd[i] = sh[i][m_addr[i]];
        m_ph[i] = lat + 1;
      end
    end else begin
      m_ph[i] = m_ph[i] - 1;
      if (m_ph[i] == 1 && !m_rw[i]) m_rdata[i][m_win[i]] = m_rd[i];
    end
  endtask

  always @(posedge clk or negedge rst_n)
    model_step(0, 1, !rst_n, bus1.p0_req, bus1.p1_req, bus1.p0_we, bus1.p1_we,
               bus1.p0_addr, bus1.p1_addr, bus1.p0_wdata, bus1.p1_wdata);

  always @(posedge clk or negedge rst_n)
    model_step(1, 3, !rst_n, bus3.p0_req, bus3.p1_req, bus3.p0_we, bus3.p1_we,
               bus3.p0_addr, bus3.p1_addr, bus3.p0_wdata, bus3.p1_wdata);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cmp_inst(input int i, input int lat, input logic g0, input logic g1,
                          input logic dn0, input logic dn1, input logic en, input logic rw,
                          input logic bsy, input logic [7:0] ad, input logic [15:0] wd,
                          input logic [15:0] rd0, input logic [15:0] rd1);
    string p;
    p = $sformatf("L%0d", lat);
    check({p, "_gnt0"},  g0,  (m_ph[i] == lat + 1) && !m_win[i]);
    check({p, "_gnt1"},  g1,  (m_ph[i] == lat + 1) &&  m_win[i]);
    check({p, "_done0"}, dn0, (m_ph[i] == 1) && !m_win[i]);
    check({p, "_done1"}, dn1, (m_ph[i] == 1) &&  m_win[i]);
    check({p, "_ram_en"}, en, m_ph[i] == lat + 1);
    check({p, "_ram_rw"}, rw, m_rw[i]);
    check({p, "_busy"},  bsy, m_ph[i] > 0);
    check({p, "_ram_addr"},  ad, m_addr[i]);
    check({p, "_ram_wdata"}, wd, m_wd[i]);
    check({p, "_rdata0"}, rd0, m_rdata[i][0]);
    check({p, "_rdata1"}, rd1, m_rdata[i][1]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, 1, bus1.p0_gnt, bus1.p1_gnt, bus1.p0_done, bus1.p1_done, bus1.ram_en,
               bus1.ram_rw, bus1.busy, bus1.ram_addr, bus1.ram_wdata, bus1.p0_rdata, bus1.p1_rdata);
      cmp_inst(1, 3, bus3.p0_gnt, bus3.p1_gnt, bus3.p0_done, bus3.p1_done, bus3.ram_en,
               bus3.ram_rw, bus3.busy, bus3.ram_addr, bus3.ram_wdata, bus3.p0_rdata, bus3.p1_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_tie [4];
    for (int a = 0; a < 256; a++) begin
      ram1[a] = init_val(a); ram3[a] = init_val(a);
      sh[0][a] = init_val(a); sh[1][a] = init_val(a);
    end
    bus1.p0_req = 0; bus1.p1_req = 0; bus1.p0_we = 0; bus1.p1_we = 0;
    bus1.p0_addr = 0; bus1.p1_addr = 0; bus1.p0_wdata = 0; bus1.p1_wdata = 0;
    bus3.p0_req = 0; bus3.p1_req = 0; bus3.p0_we = 0; bus3.p1_we = 0;
    bus3.p0_addr = 0; bus3.p1_addr = 0; bus3.p0_wdata = 0; bus3.p1_wdata = 0;
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    cmp_en = 1;

    check("rst_busy", bus1.busy, 0);
    check("rst_p0_rdata", bus1.p0_rdata, 0);
    check("rst_ram_en", bus1.ram_en, 0);
    check("rst_ram_addr", bus1.ram_addr, 0);

    // Port 0 read of 0x12, RAM_LAT=1
    bus1.p0_req = 1; bus1.p0_we = 0; bus1.p0_addr = 8'h12;
    tick();
    check("rd_gnt", bus1.p0_gnt, 1);
    check("rd_ram_en", bus1.ram_en, 1);
    check("rd_ram_addr", bus1.ram_addr, 8'h12);
    bus1.p0_req = 0;
    tick();
    check("rd_done", bus1.p0_done, 1);
    check("rd_rdata", bus1.p0_rdata, 16'hBEEF);
    tick();
    check("rd_busy_low", bus1.busy, 0);
    check("rd_rdata_held", bus1.p0_rdata, 16'hBEEF);

    // Port 1 write 0x1234 to 0x80
    bus1.p1_req = 1; bus1.p1_we = 1; bus1.p1_addr = 8'h80; bus1.p1_wdata = 16'h1234;
    tick();
    check("wr_gnt", bus1.p1_gnt, 1);
    check("wr_ram_rw", bus1.ram_rw, 1);
    check("wr_ram_addr", bus1.ram_addr, 8'h80);
    check("wr_ram_wdata", bus1.ram_wdata, 16'h1234);
    bus1.p1_req = 0; bus1.p1_we = 0;
    tick();
    check("wr_done", bus1.p1_done, 1);
    check("wr_rdata_unchanged", bus1.p1_rdata, 0);
    tick();

    // Read back the written word through port 0
    bus1.p0_req = 1; bus1.p0_addr = 8'h80;
    tick();
    bus1.p0_req = 0;
    tick();
    check("rb_rdata", bus1.p0_rdata, 16'h1234);
    tick();

    // Continuous requests from both ports after a fresh reset
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_tie = '{0, 1, 0, 1};
`else
    exp_tie = '{1, 1, 1, 1};
`endif
    bus1.p0_addr = 8'h01; bus1.p1_addr = 8'h02;
    bus1.p0_req = 1; bus1.p1_req = 1;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = -1;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (bus1.p0_gnt) begin w = 0; break; end
        if (bus1.p1_gnt) begin w = 1; break; end
      end
      check($sformatf("tie_grant%0d", k), w, exp_tie[k]);
      if (w == 0) bus1.p0_req = 0;
      else if (w == 1) bus1.p1_req = 0;
      tick();
      bus1.p0_req = 1; bus1.p1_req = 1;
    end
    bus1.p0_req = 0; bus1.p1_req = 0;
    repeat (3) tick();

    // RAM_LAT=3 read, then a back-to-back request
    bus3.p0_req = 1; bus3.p0_addr = 8'h34;
    tick();
    check("l3_gnt", bus3.p0_gnt, 1);
    check("l3_busy_t1", bus3.busy, 1);
    bus3.p0_req = 0;
    tick();
    check("l3_done_t2", bus3.p0_done, 0);
    check("l3_busy_t2", bus3.busy, 1);
    bus3.p0_req = 1; bus3.p0_addr = 8'h35;
    tick();
    check("l3_done_t3", bus3.p0_done, 0);
    tick();
    check("l3_done_t4", bus3.p0_done, 1);
    check("l3_rdata_t4", bus3.p0_rdata, 16'hC0DE);
    check("l3_busy_t4", bus3.busy, 1);
    tick();
    check("l3_busy_t5", bus3.busy, 0);
    check("l3_gnt_t5", bus3.p0_gnt, 0);
    tick();
    check("l3_gnt_t6", bus3.p0_gnt, 1);
    bus3.p0_req = 0;
    tick(); tick(); tick();
    check("l3_done2", bus3.p0_done, 1);
    check("l3_rdata2", bus3.p0_rdata, 16'hA535);
    tick();

    // Reset asserted while the RAM_LAT=3 access is in WAIT
    bus3.p0_req = 1; bus3.p0_addr = 8'h12;
    tick();
    bus3.p0_req = 0;
    tick();
    check("mid_busy_pre", bus3.busy, 1);
    rst_n = 0;
    #1;
    check("mid_busy", bus3.busy, 0);
    check("mid_rdata", bus3.p0_rdata, 0);
    check("mid_ram_addr", bus3.ram_addr, 0);
    check("mid_ram_en", bus3.ram_en, 0);
    tick();
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("mid_no_done%0d", c), bus3.p0_done, 0);
    end
    bus3.p0_req = 1; bus3.p0_addr = 8'h12;
    tick();
    check("post_gnt", bus3.p0_gnt, 1);
    bus3.p0_req = 0;
    tick(); tick(); tick();
    check("post_done", bus3.p0_done, 1);
    check("post_rdata", bus3.p0_rdata, 16'hBEEF);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter sharing the single-port synchronous program/data RAM between the CPU memory port (port 0) and an external loader/debug port (port 1). It accepts one request at a time through a req/gnt/done handshake, drives the RAM address, write data and read/write strobe, waits out the RAM read latency, and returns read data to the winning requester. It sits between the CPU top level (`address`, `data_out`, `ram_rw`, `data_in`) and the RAM instance.

## Interface
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 16: RAM data width.
- `RAM_LAT`, 1: RAM read latency in cycles, from address/strobe cycle to data; legal range 1..4.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` in 1: access request, held until `pX_gnt`.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read; stable while req high.
- `p0_addr`, `p1_addr` in ADDR_W: access address.
- `p0_wdata`, `p1_wdata` in DATA_W: write data.
- `p0_gnt`, `p1_gnt` out 1: one-cycle pulse; request accepted.
- `p0_done`, `p1_done` out 1: one-cycle pulse; access complete.
- `p0_rdata`, `p1_rdata` out DATA_W: read data; valid on `pX_done` of a read, held otherwise.
- `ram_en` out 1: one-cycle RAM access strobe.
- `ram_rw` out 1: 1 = write, 0 = read; valid when `ram_en`.
- `ram_addr` out ADDR_W, `ram_wdata` out DATA_W: RAM command fields.
- `ram_rdata` in DATA_W: RAM read data.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, pick the winner, latch its we/addr/wdata into the `ram_*` registers, go to ISSUE. With no req, stay in IDLE.
- ISSUE, one cycle: `ram_en`=1, winner `gnt`=1. Load the latency counter with RAM_LAT-1. Go to WAIT if RAM_LAT>1, else to DONE.
- WAIT: decrement the counter; go to DONE when it reaches 0.
- DONE, one cycle: sample `ram_rdata` into the winner's `rdata` (reads only), pulse the winner's `done`, return to IDLE.
- Writes take the same path; `rdata` is unchanged on writes.
- The loser's request stays pending and is re-evaluated in the next IDLE.
- `ram_addr`, `ram_wdata` and `ram_rw` hold their last values outside ISSUE; only `ram_en` qualifies them.
- A requester drops req after seeing gnt. A req still high in IDLE is a new access.
- Reset values: state IDLE; all gnt, done, `ram_en`, `ram_rw` and `busy` = 0; `ram_addr`, `ram_wdata`, `p0_rdata`, `p1_rdata` = 0; last-winner = port 1.
- Reset mid-access: the access is abandoned immediately. No done is issued and `rdata` is cleared to 0.

## Timing
- Req sampled high in IDLE at cycle T.
  - ISSUE (`gnt`, `ram_en`) at T+1.
  - DONE (`done`, new `rdata`) at T+1+RAM_LAT.
  - IDLE at T+2+RAM_LAT.
- Minimum period between grants: RAM_LAT+2 cycles.
- `ram_rdata` is sampled at the end of the DONE cycle, i.e. RAM_LAT cycles after the ISSUE edge.
- Simultaneous requests in IDLE are resolved by the arbitration policy (see Configuration). Exactly one port is granted per access.
- `busy` is 1 from T+1 through T+1+RAM_LAT inclusive.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined:
  - A tie goes to the port that did not win last.
  - The last winner is updated in every ISSUE.
  - After reset the first tie goes to port 0.
- Undefined: fixed priority, port 1 (loader) always wins ties. Port 0 can starve while port 1 requests continuously; this is accepted for load/debug use.

## Test plan
- Port 0 read: `p0_req`=1, `p0_we`=0, `p0_addr`=0x12, RAM returns 0xBEEF, RAM_LAT=1 -> `p0_gnt` and `ram_en` at T+1, `p0_done` at T+2 with `p0_rdata`=0xBEEF, `busy` low at T+3.
- Port 1 write: `p1_we`=1, `p1_addr`=0x80, `p1_wdata`=0x1234 -> `ram_rw`=1, `ram_addr`=0x80 and `ram_wdata`=0x1234 during the `ram_en` cycle; `p1_done` one cycle later; `p1_rdata` unchanged.
- Both ports requesting continuously:
  - Fixed build: four consecutive grants all to port 1.
  - Round-robin build: grants alternate 0,1,0,1.
- RAM_LAT=3 read -> `done` at T+4; next grant no earlier than T+6 (5-cycle period); `busy` high T+1..T+4.
- `rst_n` asserted during WAIT -> outputs immediately at reset values; no `done` after release; a new req afterwards completes normally.
